// File: rtl/puf_reader.sv
`default_nettype none
// ============================================================================
//  Module   : puf_reader
//  Brief    : Sequences arbiter-PUF races, majority-votes the synchronized
//             response bits and assembles a multi-word device ID.
//  Revision : 1.0  initial release
// ============================================================================
module puf_reader #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned VOTES         = 5,
  parameter int unsigned NUM_WORDS     = 3,
  parameter logic [31:0] CHAL_BASE     = 32'hA5A5_0000,
  parameter logic [31:0] CHAL_STEP     = 32'h0000_0001
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     valid_o,
  output logic                     puf_enable_o,
  output logic [31:0]              puf_challenge_o,
  input  logic [31:0]              puf_resp_i,
  output logic [32*NUM_WORDS-1:0]  id_o
);

  localparam int unsigned c_vw = $clog2(VOTES + 1);
  localparam int unsigned c_ww = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [7:0]      c_settle_last = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0]      c_vote_last   = 4'(VOTES - 1);
  localparam logic [c_ww-1:0] c_word_last   = c_ww'(NUM_WORDS - 1);
  localparam logic [c_vw-1:0] c_thresh      = c_vw'((VOTES + 1) / 2);

  if ((VOTES % 2 == 0) || (VOTES < 1) || (VOTES > 15)) begin : g_bad_votes
    $error("puf_reader: VOTES must be odd and within 1..15");
  end
  if ((SETTLE_CYCLES < 4) || (SETTLE_CYCLES > 255)) begin : g_bad_settle
    $error("puf_reader: SETTLE_CYCLES must be within 4..255");
  end
  if (NUM_WORDS < 1) begin : g_bad_words
    $error("puf_reader: NUM_WORDS must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOW    = 3'd1,
    S_HIGH   = 3'd2,
    S_COMMIT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                  r_state;
  logic [31:0]             r_sync1;
  logic [31:0]             r_sync2;
  logic [7:0]              r_cnt;
  logic [3:0]              r_vote;
  logic [c_ww-1:0]         r_word;
  logic [c_vw-1:0]         r_ones [32];
  logic                    r_busy;
  logic                    r_done;
  logic                    r_valid;
  logic                    r_en;
  logic [31:0]             r_chal;
  logic [32*NUM_WORDS-1:0] r_id;
  logic [31:0]             w_maj;

  for (genvar i = 0; i < 32; i++) begin : g_maj
    assign w_maj[i] = (r_ones[i] >= c_thresh);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cnt   <= '0;
      r_vote  <= '0;
      r_word  <= '0;
      for (int i = 0; i < 32; i++) r_ones[i] <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_en    <= 1'b0;
      r_chal  <= CHAL_BASE;
      r_id    <= '0;
    end else begin
      r_sync1 <= puf_resp_i;
      r_sync2 <= r_sync1;
      r_done  <= 1'b0;
      // Lags the state by one edge: rises the cycle after acceptance, still high in DONE.
      r_busy  <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_vote  <= '0;
            r_word  <= '0;
            r_chal  <= CHAL_BASE;
            r_id    <= '0;
            r_valid <= 1'b0;
          end
        end
        S_LOW: begin
          if (r_cnt == c_settle_last) begin
            r_cnt   <= '0;
            r_en    <= 1'b1;
            r_state <= S_HIGH;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_HIGH: begin
          if (r_cnt == c_settle_last) begin
            r_cnt <= '0;
            r_en  <= 1'b0;
            for (int i = 0; i < 32; i++) r_ones[i] <= r_ones[i] + c_vw'(r_sync2[i]);
            if (r_vote < c_vote_last) begin
              r_vote  <= r_vote + 4'd1;
              r_state <= S_LOW;
            end else begin
              r_state <= S_COMMIT;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_COMMIT: begin
          for (int k = 0; k < NUM_WORDS; k++) begin
            if (r_word == c_ww'(k)) r_id[k*32 +: 32] <= w_maj;
          end
          for (int i = 0; i < 32; i++) r_ones[i] <= '0;
          if (r_word < c_word_last) begin
            r_word  <= r_word + c_ww'(1);
            r_chal  <= r_chal + CHAL_STEP;
            r_vote  <= '0;
            r_state <= S_LOW;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_valid <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign valid_o         = r_valid;
  assign puf_enable_o    = r_en;
  assign puf_challenge_o = r_chal;
  assign id_o            = r_id;

endmodule
`default_nettype wire

// File: tb/tb_puf_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_puf_reader
//  Brief    : Self-checking bench for puf_reader with a behavioural PUF model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_puf_reader;

  localparam int c_t = 244;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, valid, en;
  logic [31:0] chal;
  logic [31:0] resp;
  logic [95:0] id;

  always #5 clk = ~clk;

  puf_reader dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .busy_o          (busy),
    .done_o          (done),
    .valid_o         (valid),
    .puf_enable_o    (en),
    .puf_challenge_o (chal),
    .puf_resp_i      (resp),
    .id_o            (id)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PUF model: 0 = constant, 1 = challenge-dependent, 2 = scripted majority pattern
  int          mode = 0;
  logic [31:0] const_val = '0;
  int          rises = 0;
  int          base_rises = 0;
  always @(posedge en) rises = rises + 1;

  function automatic logic [31:0] puf_model(input int m, input logic [31:0] cv, input int rel1,
                                            input logic e, input logic [31:0] c);
    logic [31:0] r;
    int rel, w, v;
    r = cv;
    if (m == 1) begin
      r = (e === 1'b1) ? (c ^ 32'h0F0F_0F0F) : 32'h5555_5555;
    end else if (m == 2) begin
      rel = rel1 - 1;
      r = '0;
      if (rel >= 0) begin
        w = rel / 5;
        v = rel % 5;
        if (w == 0) begin
          if (v == 0 || v == 2) r[3] = 1'b1;
          if (v == 1 || v == 2 || v == 4) r[7] = 1'b1;
        end else if (w == 1) begin
          r = 32'hFFFF_0000;
          if (v == 0 || v == 1 || v == 3) r[16] = 1'b0;
        end else begin
          r = 32'h0000_0001;
        end
      end
    end
    return r;
  endfunction

  assign resp = puf_model(mode, const_val, rises - base_rises, en, chal);

  // Enable/challenge monitor
  logic        prev_en = 1'b0;
  logic [31:0] prev_chal = '0;
  int          run_len = 0;
  int          bad_len = 0;
  int          chal_bad = 0;
  logic [31:0] chal_log[$];
  always @(negedge clk) begin
    if (en === 1'b1 && prev_en !== 1'b1) begin
      run_len = 1;
      chal_log.push_back(chal);
    end else if (en === 1'b1) begin
      run_len = run_len + 1;
    end
    if (en === 1'b0 && prev_en === 1'b1 && run_len != 8) bad_len = bad_len + 1;
    if (chal !== prev_chal && (en === 1'b1 || prev_en === 1'b1)) chal_bad = chal_bad + 1;
    prev_en   = en;
    prev_chal = chal;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [95:0] id;
    int          done_at;
  } exp_t;
  exp_t sb[$];

  task automatic run_read(input string tag, input logic [95:0] exp_id, input int kick_a, input int kick_b);
    int   n, c;
    bit   seen;
    exp_t e;
    @(negedge clk);
    start      = 1'b1;
    base_rises = rises;
    @(negedge clk);
    start = 1'b0;
    n     = cyc;
    e.id      = exp_id;
    e.done_at = n + c_t;
    sb.push_back(e);
    check({tag, "_valid_cleared"}, 96'(valid), 96'd0);
    check({tag, "_id_cleared"}, id, 96'd0);
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      c     = cyc - n;
      start = (c == kick_a || c == kick_b);
      if (c == 1) check({tag, "_busy_running"}, 96'(busy), 96'd1);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    if (!seen) begin
      check({tag, "_done_timeout"}, 96'd0, 96'd1);
    end else begin
      check({tag, "_done_cycle"}, 96'(cyc), 96'(e.done_at));
      check({tag, "_id"}, id, e.id);
      check({tag, "_busy_in_done"}, 96'(busy), 96'd1);
      @(negedge clk);
      check({tag, "_valid_after"}, 96'(valid), 96'd1);
      check({tag, "_busy_after"}, 96'(busy), 96'd0);
      check({tag, "_done_pulse"}, 96'(done), 96'd0);
      check({tag, "_id_held"}, id, e.id);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 96'(busy), 96'd0);
    check({tag, "_done"}, 96'(done), 96'd0);
    check({tag, "_valid"}, 96'(valid), 96'd0);
    check({tag, "_en"}, 96'(en), 96'd0);
    check({tag, "_chal"}, 96'(chal), 96'hA5A5_0000);
    check({tag, "_id"}, id, 96'd0);
  endtask

  typedef struct {
    int          mode;
    logic [31:0] cval;
    logic [95:0] exp_id;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int   s_log, s_len, s_chal, mism;
    vecs[0] = '{0, 32'hDEAD_BEEF, {3{32'hDEAD_BEEF}}};
    vecs[1] = '{1, 32'h0, {32'hAAAA_0F0D, 32'hAAAA_0F0E, 32'hAAAA_0F0F}};
    vecs[2] = '{2, 32'h0, {32'h0000_0001, 32'hFFFE_0000, 32'h0000_0080}};
    vecs[3] = '{0, 32'h0, 96'd0};
    vecs[4] = '{0, 32'hFFFF_FFFF, {3{32'hFFFF_FFFF}}};

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      mode      = vecs[i].mode;
      const_val = vecs[i].cval;
      s_log  = chal_log.size();
      s_len  = bad_len;
      s_chal = chal_bad;
      run_read($sformatf("vec%0d", i), vecs[i].exp_id, -1, -1);
      check($sformatf("vec%0d_pulses", i), 96'(chal_log.size() - s_log), 96'd15);
      check($sformatf("vec%0d_pulse_len", i), 96'(bad_len - s_len), 96'd0);
      check($sformatf("vec%0d_chal_stable", i), 96'(chal_bad - s_chal), 96'd0);
      mism = 0;
      for (int p = 0; p < 15; p++) begin
        if (s_log + p < chal_log.size()) begin
          if (chal_log[s_log + p] !== (32'hA5A5_0000 + 32'(p / 5))) mism++;
        end
      end
      check($sformatf("vec%0d_chal_seq", i), 96'(mism), 96'd0);
    end

    // Starts while busy are ignored; an immediate restart clears the ID
    mode      = 0;
    const_val = 32'h1234_5678;
    run_read("busy_kick", {3{32'h1234_5678}}, 50, 120);
    const_val = 32'hABCD_0123;
    run_read("restart", {3{32'hABCD_0123}}, -1, -1);

    // Reset during word 1 discards the partial ID
    const_val = 32'h0F1E_2D3C;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midreset");
    repeat (5) @(negedge clk);
    check("midreset_stays_idle", 96'(busy), 96'd0);
    check("midreset_no_enable", 96'(en), 96'd0);
    run_read("after_reset", {3{32'h0F1E_2D3C}}, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
